// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction memory loader. A byte stream arrives on a
// valid/ready port: a 16-bit little-endian word count N, then 4*N data bytes
// (little-endian within each word). Words are written into an internal
// instruction memory. The core is held in reset until the whole program has
// been received. The memory is read combinationally on the fetch port.
//
// Handshake: a byte is consumed only on a rising clk edge where ld_valid and
// ld_ready are both 1. ld_valid may be raised or dropped in any cycle. The
// ld_ready signal depends only on the FSM state, never on ld_valid.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one checksum byte follows the data. It must equal the XOR
//   of all data bytes. A mismatch ends in ERR instead of RUN.
//
// Parameters:
//   XLEN  - instruction word width. Only 32 is supported.
//   DEPTH - memory size in words. It must be a power of two and <= 32768.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous, active-high reset
//   ld_valid   - loader byte valid
//   ld_byte    - loader byte
//   ld_ready   - loader byte accepted this cycle (when ld_valid is also 1)
//   imem_addr  - byte address of the core fetch
//   imem_data  - instruction word at imem_addr, NOP if not loaded
//   core_reset - holds the core in reset until the program is loaded
//   load_done  - program loaded, core running
//   load_err   - load failed; sticky until reset
//
// Debug: the FSM state is held in state_q (type state_t).
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_valid,
    input  logic [7:0]      ld_byte,
    output logic            ld_ready,
    input  logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] imem_data,
    output logic            core_reset,
    output logic            load_done,
    output logic            load_err
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [16:0]     DEPTH_W = 17'(DEPTH);
    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);
    localparam logic [AW:0]     ONE     = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        RUN,
        ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,CSUM
`endif
    } state_t;

    // This is the state entered once the data phase is over, including the
    // N==0 case.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t POST_DATA = CSUM;
`else
    localparam state_t POST_DATA = RUN;
`endif

    state_t        state_q, state_d;
    logic [7:0]    cnt_lo_q;      // header low byte, held until the high byte arrives
    logic [AW:0]   cnt_q;         // word count N of the current load
    logic [AW:0]   widx_q;        // next word index; also the loaded-word count
    logic [1:0]    bpos_q;        // byte position within the current word
    logic [23:0]   buf_q;         // bytes 0..2 of the word being assembled
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    logic [XLEN-1:0] mem [DEPTH];

    logic          accept;
    logic [15:0]   hdr_n;
    logic          word_done;
    logic          last_word;

    assign accept    = ld_valid && ld_ready;
    assign hdr_n     = {ld_byte, cnt_lo_q};
    assign word_done = accept && (state_q == DATA) && (bpos_q == 2'd3);
    assign last_word = (widx_q + ONE) == cnt_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HDR0;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state and outputs ----------------
    always_comb begin
        state_d    = state_q;
        ld_ready   = 1'b0;
        core_reset = 1'b1;
        load_done  = 1'b0;
        load_err   = 1'b0;
        case (state_q)
            HDR0: begin
                ld_ready = 1'b1;
                if (accept) state_d = HDR1;
            end
            HDR1: begin
                ld_ready = 1'b1;
                if (accept) begin
                    if (hdr_n == 16'd0)                 state_d = POST_DATA;
                    else if ({1'b0, hdr_n} > DEPTH_W)   state_d = ERR;
                    else                                state_d = DATA;
                end
            end
            DATA: begin
                ld_ready = 1'b1;
                if (word_done && last_word) state_d = POST_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                ld_ready = 1'b1;
                if (accept) state_d = (ld_byte == csum_q) ? RUN : ERR;
            end
`endif
            RUN: begin
                core_reset = 1'b0;
                load_done  = 1'b1;
            end
            ERR: begin
                load_err = 1'b1;
            end
            default: state_d = HDR0;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_lo_q <= 8'd0;
            cnt_q    <= '0;
            widx_q   <= '0;
            bpos_q   <= 2'd0;
            buf_q    <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= 8'd0;
`endif
        end else begin
            if (accept && state_q == HDR0) cnt_lo_q <= ld_byte;
            // N > DEPTH never reaches DATA, so the truncation is harmless.
            if (accept && state_q == HDR1) cnt_q <= hdr_n[AW:0];
            if (accept && state_q == DATA) begin
                bpos_q <= bpos_q + 2'd1;
                // Shift right so byte0 ends up in the low bits after 3 bytes.
                buf_q  <= {ld_byte, buf_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_q <= csum_q ^ ld_byte;
`endif
            end
            if (word_done) widx_q <= widx_q + ONE;
        end
    end

    // The memory array is not reset. Reads are gated by widx_q, so old
    // contents are never visible after a reset.
    always_ff @(posedge clk) begin
        if (word_done) mem[widx_q[AW-1:0]] <= {ld_byte, buf_q};
    end

    // ---------------- fetch port ----------------
    logic          addr_oob;
    logic [AW-1:0] rd_idx;
    logic          unused_addr_bits;

    assign addr_oob         = |imem_addr[XLEN-1:AW+2];
    assign rd_idx           = imem_addr[AW+1:2];
    assign unused_addr_bits = ^imem_addr[1:0];
    assign imem_data        = (addr_oob || ({1'b0, rd_idx} >= widx_q)) ? NOP : mem[rd_idx];

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader: directed testbench for imem_loader (DEPTH = 256).
// Inputs are driven on the falling edge. Outputs are sampled 1 ns after the
// rising edge. Checksum bytes are computed here from the data bytes sent.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        core_reset;
    logic        load_done;
    logic        load_err;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  csum_acc;
    logic [7:0]  prog [8];

    imem_loader #(.XLEN(32), .DEPTH(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_ready   (ld_ready),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        imem_addr = addr;
        #1;
        check(tag, imem_data, exp);
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_byte  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_data(input logic [7:0] b);
        csum_acc = csum_acc ^ b;
        send(b);
    endtask

    // A cycle with ld_valid low and a junk byte on the bus.
    task automatic gap_cycle();
        @(negedge clk);
        ld_valid = 1'b0;
        ld_byte  = 8'hee;
        @(posedge clk);
        #1;
    endtask

    task automatic load_hdr(input logic [15:0] n);
        send(n[7:0]);
        send(n[15:8]);
        csum_acc = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        ld_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
    endtask

    // N=2 program load. When gap is 1, ld_valid drops between bytes.
    task automatic load_n2(input bit gap);
        load_hdr(16'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int i = 0; i < 8; i++) begin
            if (gap) gap_cycle();
            send_data(prog[i]);
        end
        if (gap) gap_cycle();
        check("core_reset_pre_final", {31'd0, core_reset}, 32'd1);
        send(csum_acc);
`else
        for (int i = 0; i < 7; i++) begin
            if (gap) gap_cycle();
            send_data(prog[i]);
        end
        if (gap) gap_cycle();
        check("core_reset_pre_final", {31'd0, core_reset}, 32'd1);
        send_data(prog[7]);
`endif
        check("core_reset_final_edge", {31'd0, core_reset}, 32'd0);
    endtask

    task automatic check_n2_image(input string tag);
        rd({tag, "_w0"}, 32'd0, 32'h00a0_0513);
        rd({tag, "_w0_unaligned"}, 32'd1, 32'h00a0_0513);
        rd({tag, "_w1"}, 32'd4, 32'h0015_0593);
        rd({tag, "_w2_nop"}, 32'd8, NOP);
        check({tag, "_load_done"}, {31'd0, load_done}, 32'd1);
        check({tag, "_ld_ready"}, {31'd0, ld_ready}, 32'd0);
        check({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
    endtask

    function automatic logic [31:0] big_word(input int i);
        return {8'(i), 8'h5a, 8'(i) ^ 8'hff, 8'hc3};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        prog[0] = 8'h13; prog[1] = 8'h05; prog[2] = 8'ha0; prog[3] = 8'h00;
        prog[4] = 8'h93; prog[5] = 8'h05; prog[6] = 8'h15; prog[7] = 8'h00;
        csum_acc  = 8'h00;
        reset     = 1'b1;
        ld_valid  = 1'b0;
        ld_byte   = 8'h00;
        imem_addr = 32'd0;
        #1;
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
        check("rst_imem_data", imem_data, NOP);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back N=2 load.
        load_n2(1'b0);
        check_n2_image("b2b");
        rd("b2b_oob", 32'd1024, NOP);
        // ld_valid is ignored in RUN.
        for (int i = 0; i < 3; i++) send(8'hff);
        check("run_sticky_done", {31'd0, load_done}, 32'd1);
        rd("run_sticky_w0", 32'd0, 32'h00a0_0513);

        // Full-depth load. Boundary: last word, and the first address past the array.
        do_reset();
        load_hdr(16'd256);
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = big_word(i);
            send_data(w[7:0]);
            send_data(w[15:8]);
            send_data(w[23:16]);
            send_data(w[31:24]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(csum_acc);
`endif
        check("full_load_done", {31'd0, load_done}, 32'd1);
        rd("full_w0", 32'd0, big_word(0));
        rd("full_w1", 32'd4, big_word(1));
        rd("full_w255", 32'd1020, big_word(255));
        rd("full_oob", 32'd1024, NOP);

        // N=2 load with ld_valid toggling. This overwrites words 0 and 1.
        do_reset();
        load_n2(1'b1);
        check_n2_image("gap");

        // N=0: straight to RUN; stale memory must read as NOP.
        do_reset();
        load_hdr(16'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(csum_acc);
`endif
        check("n0_load_done", {31'd0, load_done}, 32'd1);
        check("n0_core_reset", {31'd0, core_reset}, 32'd0);
        rd("n0_addr0", 32'd0, NOP);
        rd("n0_addr4", 32'd4, NOP);
        rd("n0_addr1020", 32'd1020, NOP);

        // N = DEPTH+1 gives ERR, which is held for 20 cycles with ld_valid high.
        do_reset();
        load_hdr(16'h0101);
        check("err_load_err", {31'd0, load_err}, 32'd1);
        check("err_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("err_core_reset", {31'd0, core_reset}, 32'd1);
        check("err_load_done", {31'd0, load_done}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            send(8'(i));
            check("err_hold_err", {31'd0, load_err}, 32'd1);
            check("err_hold_ready", {31'd0, ld_ready}, 32'd0);
        end

        // Reset asserted in the middle of a load (after 5 data bytes).
        do_reset();
        load_hdr(16'd2);
        for (int i = 0; i < 5; i++) send_data(prog[i]);
        rd("partial_w0", 32'd0, 32'h00a0_0513);
        rd("partial_w1_nop", 32'd4, NOP);
        ld_valid  = 1'b0;
        imem_addr = 32'd0;
        reset     = 1'b1;
        #1;
        check("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("mid_rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("mid_rst_load_done", {31'd0, load_done}, 32'd0);
        check("mid_rst_load_err", {31'd0, load_err}, 32'd0);
        check("mid_rst_addr0", imem_data, NOP);
        @(negedge clk);
        reset = 1'b0;
        load_n2(1'b0);
        check_n2_image("reload");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // A wrong checksum gives ERR.
        do_reset();
        load_hdr(16'd1);
        send_data(8'h13); send_data(8'h00); send_data(8'h00); send_data(8'h00);
        check("csum_acc_value", {24'd0, csum_acc}, 32'h13);
        send(8'h12);
        check("csum_bad_err", {31'd0, load_err}, 32'd1);
        check("csum_bad_done", {31'd0, load_done}, 32'd0);
        check("csum_bad_core_reset", {31'd0, core_reset}, 32'd1);
        // The correct checksum gives RUN.
        do_reset();
        load_hdr(16'd1);
        send_data(8'h13); send_data(8'h00); send_data(8'h00); send_data(8'h00);
        check("csum_pre_core_reset", {31'd0, core_reset}, 32'd1);
        send(8'h13);
        check("csum_good_done", {31'd0, load_done}, 32'd1);
        check("csum_good_err", {31'd0, load_err}, 32'd0);
        rd("csum_good_w0", 32'd0, 32'h0000_0013);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
